uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 17 +
 rtl/uart_tx_fifo.sv | 77 +++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host write port and downstream UART transmitter handshake
interface uart_tx_fifo_if #(parameter int DEPTH = 16);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_busy;
  modport master (output wr_en, wr_data, tx_busy,
                  input  full, empty, count, overflow, tx_data, tx_send);
  modport slave  (input  wr_en, wr_data, tx_busy,
                  output full, empty, count, overflow, tx_data, tx_send);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a UART transmitter one byte per busy cycle
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, overflow_q, tx_send_q;
  logic [7:0]    tx_data_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    mem_q [DEPTH];
  logic          push, pop;
  // Writes judged against the registered full flag, so a same-cycle pop never rescues a write into a full FIFO
  assign push    = bus.wr_en && !full_q;
  assign pop     = (state_q == IDLE) && !empty_q && !bus.tx_busy;
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_send  = tx_send_q;
  // Storage array; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end
  // Send sequencing: pop, wait for the transmitter to go busy (or give up), then wait for it to finish
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE:      if (pop) begin state_d = WAIT_BUSY; tmo_d = '0; end
      WAIT_BUSY: if (bus.tx_busy) state_d = WAIT_DONE;
                 else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) state_d = IDLE;
                 else tmo_d = tmo_q + TW'(1);
      WAIT_DONE: if (!bus.tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // State, pointers, occupancy flags and transmitter outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_send_q  <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      count_q    <= count_d;
      full_q     <= count_d == CW'(DEPTH);
      empty_q    <= count_d == '0;
      overflow_q <= bus.wr_en && full_q;
      tx_send_q  <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        tx_data_q <= mem_q[rd_ptr_q];
      end
    end
  end
endmodule
